cam_frame_writer: RTL and testbench

Write-side producer for the ping-pong frame buffer. Captures an OV7670-style byte stream (vsync/href/8-bit data, RGB565 as two bytes per pixel) and assembles pixels. Decimates the source frame 2:1 in both axes to DST_W×DST_H. Drives the buffer's write port (`we`, `wAddr`, `wData`) and toggles `buffer_sel` after every complete frame, so the VGA-side reader always has one finished frame and one frame in progress.

---
 rtl/cam_frame_writer.sv | 152 +++++++++++++++
 tb/tb_cam_frame_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - OV7670 byte-stream capture, 2:1 decimation, ping-pong frame buffer writer
// Optional feature macro: CAM_BYTE_SWAP_EN (first camera byte lands in wData[7:0]).
module cam_frame_writer #(
    parameter int DST_W = 160,
    parameter int DST_H = 120,
    parameter int AW    = $clog2(DST_W*DST_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    cam_data,
    output logic          we,
    output logic [AW-1:0] wAddr,
    output logic [15:0]   wData,
    output logic          buffer_sel,
    output logic          frame_done,
    output logic          frame_err,
    output logic          capturing
);
    localparam int CW = 16;
    localparam logic [CW-1:0] SRC_W = CW'(2*DST_W);
    localparam logic [CW-1:0] SRC_H = CW'(2*DST_H);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic            vsync_q, href_q, vsync_p_q, href_p_q;
    logic [7:0]      data_q;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]   line_cnt_q, line_cnt_d;
    logic [7:0]      first_q, first_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            sel_q, sel_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cap_q, cap_d;
    logic            vs_rise, vs_fall, hr_rise, hr_fall;
    logic [CW-1:0]   idx, col;

    always_comb begin
        vs_rise = vsync_q & ~vsync_p_q;
        vs_fall = ~vsync_q & vsync_p_q;
        hr_rise = href_q & ~href_p_q;
        hr_fall = ~href_q & href_p_q;
        // The byte seen on an href rise is byte 0 of the new line.
        idx = hr_rise ? '0 : byte_cnt_q;
        col = idx >> 1;

        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        first_d    = first_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (vsync_q) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d    = ACTIVE;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // A line still open here never saw its href fall, so it is not counted.
                    state_d = SYNC;
                    if (line_cnt_q == SRC_H) begin
                        done_d = 1'b1;
                        sel_d  = ~sel_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (href_q) begin
                    byte_cnt_d = (&idx) ? idx : idx + CW'(1);
                    if (!idx[0]) begin
                        first_d = data_q;
                    end else if (!col[0] && !line_cnt_q[0] && col < SRC_W && line_cnt_q < SRC_H) begin
                        we_d    = 1'b1;
                        waddr_d = AW'(line_cnt_q >> 1) * AW'(DST_W) + AW'(col >> 1);
`ifdef CAM_BYTE_SWAP_EN
                        wdata_d = {data_q, first_q};
`else
                        wdata_d = {first_q, data_q};
`endif
                    end
                end else if (hr_fall && byte_cnt_q != '0 && line_cnt_q != '1) begin
                    line_cnt_d = line_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cap_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= '0;
            vsync_p_q  <= 1'b0;
            href_p_q   <= 1'b0;
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
            first_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            data_q     <= cam_data;
            vsync_p_q  <= vsync_q;
            href_p_q   <= href_q;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
            first_q    <= first_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign buffer_sel = sel_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign capturing  = cap_q;
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - scoreboard bench for cam_frame_writer (reduced frame size, random frames)
module tb_cam_frame_writer;
    localparam int DST_W = 8;
    localparam int DST_H = 6;
    localparam int AW    = $clog2(DST_W*DST_H);
    localparam int SRC_W = 2*DST_W;
    localparam int SRC_H = 2*DST_H;
    localparam int LB    = 2*SRC_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    cam_data = '0;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          buffer_sel, frame_done, frame_err, capturing;

    cam_frame_writer #(.DST_W(DST_W), .DST_H(DST_H), .AW(AW)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
        .we(we), .wAddr(wAddr), .wData(wData), .buffer_sel(buffer_sel),
        .frame_done(frame_done), .frame_err(frame_err), .capturing(capturing)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic sel; logic [AW-1:0] addr; logic [15:0] data;} wr_t;
    typedef struct packed {logic done; logic sel;} ev_t;

    wr_t  exp_wr[$];
    ev_t  exp_ev[$];
    wr_t  e_wr;
    ev_t  e_ev;
    int   errors = 0;
    int   checks = 0;
    int   wr_count = 0;
    int   m_line = 0;
    logic m_sel = 1'b0;
    bit   m_off = 1'b0;
    bit   chk_const = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] pix(input logic [7:0] b0, input logic [7:0] b1);
`ifdef CAM_BYTE_SWAP_EN
        return {b1, b0};
`else
        return {b0, b1};
`endif
    endfunction

    // Reference: source pixel (x, m_line) lands at (m_line/2)*DST_W + x/2 when both are even and in range.
    task automatic model_pixel(input int x, input logic [7:0] b0, input logic [7:0] b1);
        wr_t w;
        if (!m_off && x % 2 == 0 && m_line % 2 == 0 && x < SRC_W && m_line < SRC_H) begin
            w.sel  = m_sel;
            w.addr = AW'((m_line/2)*DST_W + x/2);
            w.data = pix(b0, b1);
            exp_wr.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int len, input int mode, input bit keep_open);
        logic [7:0] b0, b;
        b0 = '0;
        for (int i = 0; i < len; i++) begin
            if (mode == 0) b = (i % 2 == 0) ? 8'(i/2) : 8'(m_line);
            else           b = 8'($urandom);
            if (mode == 0 && m_line == 0 && i < 2) b = (i == 0) ? 8'hAB : 8'hCD;
            href = 1'b1;
            cam_data = b;
            if (i % 2 == 0) b0 = b;
            else model_pixel(i/2, b0, b);
            tick();
        end
        if (!keep_open) begin
            href = 1'b0;
            cam_data = '0;
            if (len > 0) m_line++;
            repeat (3) tick();
        end
    endtask

    task automatic run_frame(input int nlines, input int mode, input bit rnd, input int odd_y, input int abort_len);
        ev_t ev;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        check("capturing_active", 32'(capturing), 32'd1);
        m_line = 0;
        wr_count = 0;
        for (int y = 0; y < nlines; y++)
            send_line(rnd ? int'($urandom_range(1, 2*LB+3)) : ((y == odd_y) ? LB+1 : LB), mode, 1'b0);
        if (abort_len > 0) begin
            send_line(abort_len, mode, 1'b1);
            cam_data = 8'($urandom);
        end
        vsync = 1'b1;
        ev.done = (m_line == SRC_H);
        ev.sel  = ev.done ? ~m_sel : m_sel;
        exp_ev.push_back(ev);
        m_sel = ev.sel;
        @(posedge clk);
        #1;
        href = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("event_latency", 32'(frame_done | frame_err), 32'd1);
        repeat (3) tick();
        check("capturing_idle", 32'(capturing), 32'd0);
    endtask

    task automatic check_zero_outputs();
        @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(wAddr), 32'd0);
        check("rst_wdata", 32'(wData), 32'd0);
        check("rst_sel", 32'(buffer_sel), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_capturing", 32'(capturing), 32'd0);
    endtask

    always @(negedge clk) begin
        if (we) begin
            wr_count++;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no_write", wAddr, wData);
            end else begin
                e_wr = exp_wr.pop_front();
                check("write_sel_addr_data", 32'({buffer_sel, wAddr, wData}), 32'(e_wr));
            end
            if (chk_const && wAddr == AW'(0))
`ifdef CAM_BYTE_SWAP_EN
                check("byte_order", 32'(wData), 32'h0000CDAB);
`else
                check("byte_order", 32'(wData), 32'h0000ABCD);
`endif
            if (chk_const && wAddr == AW'(DST_W+1))
                check("pixel_2_2", 32'(wData), 32'h00000202);
        end
        if (frame_done || frame_err) begin
            check("event_expected", 32'(exp_ev.size() > 0), 32'd1);
            if (exp_ev.size() > 0) begin
                e_ev = exp_ev.pop_front();
                check("frame_event", 32'({frame_done, frame_err, buffer_sel}), 32'({e_ev.done, ~e_ev.done, e_ev.sel}));
            end
            check("writes_drained", 32'(exp_wr.size()), 32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check_zero_outputs();
        reset = 1'b0;
        tick();

        chk_const = 1'b1;
        run_frame(SRC_H, 0, 1'b0, -1, 0);
        chk_const = 1'b0;
        check("full_frame_writes", 32'(wr_count), 32'(DST_W*DST_H));
        check("sel_after_frame1", 32'(buffer_sel), 32'd1);

        run_frame(SRC_H, 1, 1'b0, -1, 0);
        check("sel_after_frame2", 32'(buffer_sel), 32'd0);

        run_frame(5, 1, 1'b0, -1, 0);
        check("short_frame_writes", 32'(wr_count), 32'(3*DST_W));
        check("sel_after_short", 32'(buffer_sel), 32'd0);

        run_frame(SRC_H, 1, 1'b0, 2, 0);
        check("odd_line_writes", 32'(wr_count), 32'(DST_W*DST_H));

        run_frame(SRC_H, 1, 1'b0, -1, 7);
        run_frame(SRC_H-2, 1, 1'b0, -1, 5);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = SRC_H - 1 + int'($urandom_range(0, 2));
            run_frame(n, 1, 1'b1, -1, (f % 3 == 2) ? int'($urandom_range(1, 9)) : 0);
        end

        // Reset in the middle of an odd source line, then an unsynchronised line, then a full frame.
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        m_line = 0;
        for (int y = 0; y < 5; y++) send_line(LB, 1, 1'b0);
        send_line(6, 1, 1'b1);
        reset = 1'b1;
        check_zero_outputs();
        tick();
        check_zero_outputs();
        href = 1'b0;
        tick();
        reset = 1'b0;
        m_sel = 1'b0;
        m_off = 1'b1;
        wr_count = 0;
        tick();
        send_line(LB, 1, 1'b0);
        send_line(LB, 1, 1'b0);
        m_off = 1'b0;
        check("no_write_before_sync", 32'(wr_count), 32'd0);
        run_frame(SRC_H, 1, 1'b0, -1, 0);
        check("post_reset_writes", 32'(wr_count), 32'(DST_W*DST_H));
        check("post_reset_sel", 32'(buffer_sel), 32'd1);

        repeat (10) tick();
        check("pending_writes_end", 32'(exp_wr.size()), 32'd0);
        check("pending_events_end", 32'(exp_ev.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
